// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider: default widths, reset divisor
// and the smallest divisor a load may request.
package clk_div_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 4;
    localparam int MIN_DIV         = 2;

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor staging: validates load requests, holds the pending divisor until the top
// level consumes it at a period boundary, and flags rejected loads.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CNT_W-1:0] i_div_in,
    input  logic             i_div_load,
    input  logic             i_apply,
    output logic [CNT_W-1:0] o_pend_div,
    output logic             o_pending,
    output logic             o_div_err
);

    logic             w_valid;
    logic             r_pending;
    logic             r_err;
    logic [CNT_W-1:0] r_pend_div;

    assign w_valid = (i_div_in >= CNT_W'(MIN_DIV));

    // A fresh load beats consumption, so a load landing on a boundary stays pending
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= i_div_load && !w_valid;
            if (i_div_load && w_valid) begin
                r_pending <= 1'b1;
            end else if (i_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_div_load && w_valid) begin
            r_pend_div <= i_div_in;
        end
    end

    assign o_pend_div = r_pend_div;
    assign o_pending  = r_pending;
    assign o_div_err  = r_err;

endmodule

// File: rtl/clk_divider_prog.sv
// Programmable clock divider: phase counter with low phase first, registered clock
// and rise-tick outputs, and glitch-free divisor changes at period boundaries.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clock_out,
    output logic             rise_tick,
    output logic [CNT_W-1:0] div_active,
    output logic             div_pending,
    output logic             div_err
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_clk;
    logic             r_rise;

    logic             w_last;
    logic             w_apply;
    logic             w_pending;
    logic [CNT_W-1:0] w_pend_div;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_low_nxt;

    function automatic logic [CNT_W-1:0] f_low_len(input logic [CNT_W-1:0] d);
        return d - (d >> 1);
    endfunction

    clk_div_cfg #(
        .CNT_W (CNT_W)
    ) u_cfg (
        .i_clk      (clock_in),
        .i_rst_n    (reset_n),
        .i_div_in   (div_in),
        .i_div_load (div_load),
        .i_apply    (w_apply),
        .o_pend_div (w_pend_div),
        .o_pending  (w_pending),
        .o_div_err  (div_err)
    );

    // Outputs are registered from the next-state values so they line up with r_cnt
    always_comb begin
        w_last    = (r_cnt == r_div - CNT_W'(1));
        w_apply   = enable && w_last && w_pending;
        w_cnt_nxt = r_cnt;
        w_div_nxt = r_div;
        if (enable) begin
            if (w_last) begin
                w_cnt_nxt = '0;
                if (w_pending) begin
                    w_div_nxt = w_pend_div;
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
        w_low_nxt = f_low_len(w_div_nxt);
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_div  <= CNT_W'(DEFAULT_DIV);
            r_clk  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_div  <= w_div_nxt;
            r_clk  <= (w_cnt_nxt >= w_low_nxt);
            r_rise <= enable && (w_cnt_nxt == w_low_nxt);
        end
    end

    assign clock_out   = r_clk;
    assign rise_tick   = r_rise;
    assign div_active  = r_div;
    assign div_pending = w_pending;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: directed scenarios plus a randomized run,
// all compared against a queue-of-phases reference model.
module tb_clk_divider_prog;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;
    localparam int VW      = CNT_W + 4;

    logic             clock_in = 1'b0;
    logic             reset_n  = 1'b0;
    logic             enable   = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_in   = '0;
    logic             clock_out;
    logic             rise_tick;
    logic             div_pending;
    logic             div_err;
    logic [CNT_W-1:0] div_active;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock_in = ~clock_in;

    clk_divider_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .enable      (enable),
        .div_in      (div_in),
        .div_load    (div_load),
        .clock_out   (clock_out),
        .rise_tick   (rise_tick),
        .div_active  (div_active),
        .div_pending (div_pending),
        .div_err     (div_err)
    );

    // Reference model: the remaining phases of the current period as a queue of levels
    bit m_q[$];
    int m_div      = DEF_DIV;
    bit m_pend     = 1'b0;
    int m_pend_val = 0;
    bit m_err      = 1'b0;
    bit m_prev_en  = 1'b0;
    bit m_last     = 1'b1;

    function automatic void m_refill(input int d);
        m_q.delete();
        for (int i = 0; i < d; i++) m_q.push_back(i >= d - d / 2);
    endfunction

    function automatic void m_edge(input bit rstn, input bit en, input bit ld, input int din);
        if (!rstn) begin
            m_div     = DEF_DIV;
            m_refill(m_div);
            m_pend    = 1'b0;
            m_err     = 1'b0;
            m_prev_en = 1'b0;
            m_last    = 1'b1;
        end else begin
            m_err = ld && (din < 2);
            if (en) begin
                m_last = m_q.pop_front();
                if (m_q.size() == 0) begin
                    if (m_pend) begin
                        m_div  = m_pend_val;
                        m_pend = 1'b0;
                    end
                    m_refill(m_div);
                end
            end
            if (ld && din >= 2) begin
                m_pend     = 1'b1;
                m_pend_val = din;
            end
            m_prev_en = en;
        end
    endfunction

    function automatic int m_cnt();
        return m_div - m_q.size();
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_q[0], m_prev_en && m_q[0] && !m_last, m_pend, m_err, CNT_W'(m_div)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {clock_out, rise_tick, div_pending, div_err, div_active};
    endfunction

    task automatic step(input bit rstn, input bit en, input bit ld, input int din);
        reset_n  = rstn;
        enable   = en;
        div_load = ld;
        div_in   = CNT_W'(din);
        @(posedge clock_in);
        m_edge(rstn, en, ld, din);
        #1;
    endtask

    task automatic advance_to(input int c);
        for (int k = 0; k < 600 && m_cnt() != c; k++) step(1, 1, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 9);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL reset cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (div_active !== CNT_W'(DEF_DIV) || clock_out !== 1'b0 || div_pending !== 1'b0)
            $display("FAIL reset_vals: got div=%0d clk=%b pend=%b want div=%0d clk=0 pend=0",
                     div_active, clock_out, div_pending, DEF_DIV);
        else n_pass++;
    endtask

    task automatic test_default();
        int rises = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, 0);
            rises += int'(rise_tick);
            n_checks++;
            if (dut_vec() !== exp_vec() || clock_out !== (((i + 1) % 4) >= 2))
                $display("FAIL default cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (rises !== 4) $display("FAIL default_rises: got %0d want 4", rises);
        else n_pass++;
    endtask

    task automatic test_err();
        int errs = 0;
        step(1, 1, 1, 0);
        errs += int'(div_err);
        step(1, 1, 1, 1);
        errs += int'(div_err);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0);
            errs += int'(div_err);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL err cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (errs !== 2 || div_active !== CNT_W'(4) || div_pending !== 1'b0)
            $display("FAIL err_summary: got errs=%0d div=%0d pend=%b want 2/4/0",
                     errs, div_active, div_pending);
        else n_pass++;
    endtask

    task automatic test_load5();
        advance_to(1);
        step(1, 1, 1, 5);
        for (int i = 0; i < 14; i++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL load5 cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (div_active !== CNT_W'(5)) $display("FAIL load5_active: got %0d want 5", div_active);
        else n_pass++;
    endtask

    task automatic test_overwrite();
        bit seen6 = 1'b0;
        advance_to(0);
        step(1, 1, 1, 6);
        step(1, 1, 1, 8);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            if (div_active == CNT_W'(6)) seen6 = 1'b1;
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL overwrite cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (seen6 || div_active !== CNT_W'(8))
            $display("FAIL overwrite_final: got div=%0d seen6=%b want 8/0", div_active, seen6);
        else n_pass++;
    endtask

    task automatic test_enable_hold();
        advance_to(m_div - m_div / 2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (dut_vec() !== exp_vec() || clock_out !== 1'b1 || rise_tick !== 1'b0)
                $display("FAIL hold cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL resume cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_boundary_load();
        advance_to(m_div - 1);
        step(1, 1, 1, 6);
        for (int i = 0; i < 16; i++) begin
            step(1, (i % 5) != 2, i == 3, 3);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL boundary cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        step(1, 0, 1, 6);
        n_checks++;
        if (dut_vec() !== exp_vec())
            $display("FAIL disabled_load: got %b want %b", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen7 = 1'b0;
        for (int k = 0; k < 40 && m_div < 4; k++) step(1, 1, 0, 0);
        advance_to(0);
        step(1, 1, 1, 7);
        advance_to(3);
        step(0, 1, 1, 9);
        n_checks++;
        if (dut_vec() !== exp_vec() || div_active !== CNT_W'(DEF_DIV) || div_pending !== 1'b0)
            $display("FAIL reset_mid: got %b want %b", dut_vec(), exp_vec());
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            if (div_active == CNT_W'(7)) seen7 = 1'b1;
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL after_reset cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (seen7) $display("FAIL reset_discard: got seen7=1 want 0");
        else n_pass++;
    endtask

    task automatic test_max();
        int fails = 0;
        step(1, 1, 1, 255);
        for (int i = 0; i < 520; i++) begin
            step(1, 1, 0, 0);
            if (dut_vec() !== exp_vec()) begin
                if (fails < 3) $display("FAIL max cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
                fails++;
            end
        end
        n_checks++;
        if (fails != 0 || div_active !== CNT_W'(255))
            $display("FAIL max_summary: got %0d bad cycles div=%0d want 0/255", fails, div_active);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bit rstn = ($urandom_range(0, 199) != 0);
            bit en   = ($urandom_range(0, 3) != 0);
            bit ld   = ($urandom_range(0, 9) == 0);
            int din  = $urandom_range(0, 12);
            step(rstn, en, ld, din);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_err();
        test_load5();
        test_overwrite();
        test_enable_hold();
        test_boundary_load();
        test_reset_mid();
        test_max();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter CNT_W, default 16, width of divisor and phase counter.
REQ-002 Parameter DEFAULT_DIV, default 4, divisor active after reset; SHALL satisfy 2 <= DEFAULT_DIV <= 2^CNT_W-1.
REQ-003 clock_in  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  high: divider advances; low: divider freezes.
REQ-006 div_in  input  CNT_W  requested divisor, sampled when div_load=1.
REQ-007 div_load  input  1  single-cycle request to stage div_in.
REQ-008 clock_out  output  1  registered divided clock.
REQ-009 rise_tick  output  1  one-cycle pulse in the first cycle that clock_out is high.
REQ-010 div_active  output  CNT_W  divisor currently in effect.
REQ-011 div_pending  output  1  staged divisor awaiting a period boundary.
REQ-012 div_err  output  1  one-cycle pulse for a rejected load.

Function
REQ-013 Phase counter cnt SHALL count 0..div_active-1 on each enabled cycle and wrap to 0 after div_active-1.
REQ-014 low_len = div_active - (div_active>>1); high_len = div_active>>1; e.g. div 4 -> 2 low/2 high, div 5 -> 3 low/2 high.
REQ-015 clock_out SHALL be 1 exactly while cnt >= low_len; it is registered, with no combinational path from inputs.
REQ-016 Each period SHALL start with the low phase at cnt=0.
REQ-017 rise_tick SHALL be 1 only in the cycle where cnt == low_len and the previous cycle was enabled.
REQ-018 With enable=0, cnt, clock_out and div_active SHALL hold; rise_tick SHALL be 0; loads are still accepted.
REQ-019 On div_load=1 with div_in >= 2, div_in SHALL be registered as pending and div_pending set the next cycle.
REQ-020 On div_load=1 with div_in < 2, pending SHALL be unchanged and div_err SHALL pulse for one cycle, the next cycle.
REQ-021 A load while div_pending=1 SHALL overwrite the staged value (last valid load wins).
REQ-022 At the period boundary (enabled cycle with cnt == div_active-1), if div_pending=1, div_active SHALL take the staged value, cnt SHALL wrap to 0 and div_pending SHALL clear.
REQ-023 A load in the same cycle as a boundary SHALL NOT apply at that boundary; it applies at the following boundary.
REQ-024 A divisor change SHALL never shorten or stretch the period in progress, so clock_out has no runt pulses.
REQ-025 Counter arithmetic SHALL be CNT_W bits wide; div_in = 2^CNT_W-1 SHALL work without overflow.

Reset
REQ-026 While reset_n=0 at a clock edge: cnt=0, clock_out=0, rise_tick=0, div_err=0, div_pending=0, div_active=DEFAULT_DIV.
REQ-027 Reset mid-period SHALL discard the partial period and any staged divisor; the first cycle after release is cnt=0, low phase.
REQ-028 Reset SHALL take priority over enable and div_load in the same cycle.

Structure
REQ-029 Shared package clk_div_pkg SHALL hold CNT_W default, DEFAULT_DIV default and MIN_DIV=2.
REQ-030 One sub-module, clk_div_cfg, SHALL hold load validation, the pending register and div_err; phase counter and output logic stay in the top level.

Verification
REQ-031 Reset, enable=1, default div 4: clock_out = 0,0,1,1 repeating; rise_tick every 4th cycle, at cnt=2.
REQ-032 Load div_in=5 mid-period: current 4-cycle period completes, then 3 low/2 high; div_pending is 1 from the cycle after load until the boundary.
REQ-033 Load 0, then 1: div_err pulses twice; div_active stays 4; div_pending stays 0.
REQ-034 Load 6, then 8 before the boundary: only 8 is applied (4 low/4 high); 6 is never observed.
REQ-035 Drop enable for 3 cycles in the high phase: clock_out stays 1, cnt frozen, no rise_tick, and the period resumes intact.
REQ-036 Assert reset_n=0 for one cycle at cnt=3 with 7 pending: outputs and state return to REQ-026 values and 7 is never applied.
